// File: rtl/shrimp_pkg.sv
// Shared constants and types for the shrimp register file and the blocks
// that write into it.
package shrimp_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/shrimp_rr_arbiter.sv
// Round-robin arbiter with a registered "last winner" pointer.
// The search starts one past the previous winner and wraps modulo NUM_REQ.
// When advance is low no grant is issued and the pointer holds.
module shrimp_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               granted
);

    logic [PTR_W-1:0] last_grant;

    // Combinational search starting after the previous winner.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = last_grant;
        granted   = 1'b0;
        if (advance) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_grant) + k) % NUM_REQ;
                if (!granted && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = PTR_W'(idx);
                    granted    = 1'b1;
                end
            end
        end
    end

    // Pointer resets to the last requester so requester 0 wins first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PTR_W'(NUM_REQ - 1);
        end else if (granted) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/shrimp_regfile_wb_arbiter.sv
// Shares the single regfile write port among NUM_REQ writeback requesters
// and keeps a pending-write scoreboard for decode hazard checks.
// The write port is registered, so the regfile commits one cycle after the
// grant; the scoreboard bit clears on that same commit edge.
module shrimp_regfile_wb_arbiter
    import shrimp_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = shrimp_pkg::ADDR_W,
    parameter int DATA_W   = shrimp_pkg::DATA_W,
    parameter int NUM_REGS = shrimp_pkg::NUM_REGS
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        wb_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] wb_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wb_data,
    output logic [NUM_REQ-1:0]        wb_ready,
    input  logic                      wb_stall,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_addr,
    output logic                      claim_ready,
    input  logic [ADDR_W-1:0]         rd_a_addr,
    input  logic [ADDR_W-1:0]         rd_b_addr,
    output logic                      rd_a_busy,
    output logic                      rd_b_busy,
    output logic [ADDR_W-1:0]         reg_w_addr,
    output logic [DATA_W-1:0]         reg_w_val,
    output logic                      reg_w_enable,
    output logic [NUM_REGS-1:0]       pending
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    win_idx;
    logic                transfer;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   data_p1;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_next;
    logic                claim_take;
    logic                retire_hit;

    shrimp_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (wb_valid),
        .advance   (~wb_stall),
        .grant     (grant),
        .grant_idx (win_idx),
        .granted   (transfer)
    );

    assign wb_ready = grant;
    assign win_addr = wb_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = wb_data[win_idx*DATA_W +: DATA_W];

    // Stage p0 -> p1: capture the winning write; addr/data hold when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= transfer;
            if (transfer) begin
                addr_p1 <= win_addr;
                data_p1 <= win_data;
            end
        end
    end

    assign reg_w_enable = vld_p1;
    assign reg_w_addr   = addr_p1;
    assign reg_w_val    = data_p1;

    // A register being retired this cycle may be re-claimed at once.
    assign retire_hit  = vld_p1 && (addr_p1 == claim_addr);
    assign claim_ready = ~pend_q[claim_addr] | retire_hit;
    assign claim_take  = claim_valid & claim_ready;

    // Scoreboard update: clear on commit first, then set, so set wins.
    always_comb begin
        pend_next = pend_q;
        if (vld_p1) begin
            pend_next[addr_p1] = 1'b0;
        end
        if (claim_take) begin
            pend_next[claim_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end

    assign pending   = pend_q;
    assign rd_a_busy = pend_q[rd_a_addr];
    assign rd_b_busy = pend_q[rd_b_addr];

endmodule

// File: tb/tb_shrimp_regfile_wb_arbiter.sv
// Bench for shrimp_regfile_wb_arbiter: table of arbitration vectors plus
// hand sequences for scoreboard and reset corner cases. Expected writes are
// queued when a grant is expected and popped after the following edge.
module tb_shrimp_regfile_wb_arbiter;
    import shrimp_pkg::*;

    localparam int NR = 3;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NR-1:0]         wb_valid;
    logic [NR*ADDR_W-1:0]  wb_addr;
    logic [NR*DATA_W-1:0]  wb_data;
    logic [NR-1:0]         wb_ready;
    logic                  wb_stall;
    logic                  claim_valid;
    reg_addr_t             claim_addr;
    logic                  claim_ready;
    reg_addr_t             rd_a_addr;
    reg_addr_t             rd_b_addr;
    logic                  rd_a_busy;
    logic                  rd_b_busy;
    reg_addr_t             reg_w_addr;
    reg_data_t             reg_w_val;
    logic                  reg_w_enable;
    logic [NUM_REGS-1:0]   pending;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_t;

    typedef struct {
        logic [NR-1:0]        valid;
        logic [NR*ADDR_W-1:0] addr;
        logic [NR*DATA_W-1:0] data;
        logic                 stall;
        logic [NR-1:0]        exp_ready;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[14];
    int   n_vec = 0;
    int   n_bad = 0;

    shrimp_regfile_wb_arbiter #(
        .NUM_REQ  (NR),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .wb_stall     (wb_stall),
        .claim_valid  (claim_valid),
        .claim_addr   (claim_addr),
        .claim_ready  (claim_ready),
        .rd_a_addr    (rd_a_addr),
        .rd_b_addr    (rd_b_addr),
        .rd_a_busy    (rd_a_busy),
        .rd_b_busy    (rd_b_busy),
        .reg_w_addr   (reg_w_addr),
        .reg_w_val    (reg_w_val),
        .reg_w_enable (reg_w_enable),
        .pending      (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic [NR*ADDR_W-1:0] a,
                         input logic [NR*DATA_W-1:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    // Compare the grant and queue the write it should produce.
    task automatic expect_grant(input string name, input logic [NR-1:0] exp_ready);
        wr_t e;
        check({name, " ready"}, 32'(wb_ready), 32'(exp_ready));
        for (int i = 0; i < NR; i++) begin
            if (exp_ready[i]) begin
                e.addr = wb_addr[i*ADDR_W +: ADDR_W];
                e.data = wb_data[i*DATA_W +: DATA_W];
                exp_q.push_back(e);
            end
        end
    endtask

    // Advance one clock and compare the write port against the scoreboard.
    task automatic tick(input string name);
        wr_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, " wen"},   32'(reg_w_enable), 32'd1);
            check({name, " waddr"}, 32'(reg_w_addr),   32'(e.addr));
            check({name, " wval"},  32'(reg_w_val),    32'(e.data));
        end else begin
            check({name, " wen"}, 32'(reg_w_enable), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001};
        tbl[1]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b010};
        tbl[2]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b100};
        tbl[3]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001};
        tbl[4]  = '{3'b010, {4'h0, 4'h5, 4'h0}, {8'h00, 8'hA7, 8'h00}, 1'b0, 3'b010};
        tbl[5]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b1, 3'b000};
        tbl[6]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b1, 3'b000};
        tbl[7]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b1, 3'b000};
        tbl[8]  = '{3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b100};
        tbl[9]  = '{3'b011, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001};
        tbl[10] = '{3'b011, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b010};
        tbl[11] = '{3'b101, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b100};
        tbl[12] = '{3'b101, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b001};
        tbl[13] = '{3'b000, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'b000};

        reset_n     = 1'b0;
        wb_stall    = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        rd_a_addr   = '0;
        rd_b_addr   = '0;
        drive(3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11});

        repeat (2) @(posedge clock);
        #1;
        check("reset wen",     32'(reg_w_enable), 32'd0);
        check("reset waddr",   32'(reg_w_addr),   32'd0);
        check("reset wval",    32'(reg_w_val),    32'd0);
        check("reset pending", 32'(pending),      32'd0);
        reset_n = 1'b1;

        // Arbitration table: order, wrap, single requester, stall, sparse masks.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].valid, tbl[i].addr, tbl[i].data);
            wb_stall = tbl[i].stall;
            #4;
            expect_grant($sformatf("vec%0d", i), tbl[i].exp_ready);
            tick($sformatf("vec%0d", i));
        end
        wb_stall = 1'b0;
        check("hold waddr",    32'(reg_w_addr), 32'h1);
        check("hold wval",     32'(reg_w_val),  32'h11);
        check("table pending", 32'(pending),    32'h0);

        // Claim r3, duplicate claim refused, busy until the commit edge.
        drive(3'b000, '0, '0);
        claim_valid = 1'b1;
        claim_addr  = 4'h3;
        rd_a_addr   = 4'h3;
        rd_b_addr   = 4'h3;
        #4;
        check("claim3 ready", 32'(claim_ready), 32'd1);
        check("pre busy a",   32'(rd_a_busy),   32'd0);
        expect_grant("claim3", 3'b000);
        tick("claim3");
        check("claim3 pending", 32'(pending),   32'h0008);
        check("busy a",         32'(rd_a_busy), 32'd1);
        check("busy b",         32'(rd_b_busy), 32'd1);

        drive(3'b001, {4'h0, 4'h0, 4'h3}, {8'h00, 8'h00, 8'h5A});
        #4;
        check("dup claim3 ready", 32'(claim_ready), 32'd0);
        expect_grant("wr3", 3'b001);
        tick("wr3");

        drive(3'b000, '0, '0);
        claim_addr = 4'h9;
        #4;
        check("busy a at commit", 32'(rd_a_busy),   32'd1);
        check("claim9 ready",     32'(claim_ready), 32'd1);
        expect_grant("claim9", 3'b000);
        tick("claim9");
        check("clr3 set9 pending", 32'(pending),   32'h0200);
        check("busy a cleared",    32'(rd_a_busy), 32'd0);
        check("busy b cleared",    32'(rd_b_busy), 32'd0);

        // Re-claim r7 in the cycle it retires: set wins over clear.
        claim_addr = 4'h7;
        drive(3'b100, {4'h7, 4'h0, 4'h0}, {8'hC4, 8'h00, 8'h00});
        #4;
        check("claim7 ready", 32'(claim_ready), 32'd1);
        expect_grant("wr7", 3'b100);
        tick("wr7");
        check("claim7 pending", 32'(pending), 32'h0280);

        drive(3'b010, {4'h0, 4'h9, 4'h0}, {8'h00, 8'h99, 8'h00});
        #4;
        check("reclaim7 ready", 32'(claim_ready), 32'd1);
        expect_grant("wr9", 3'b010);
        tick("setwins");
        check("setwins pending", 32'(pending), 32'h0280);

        claim_addr = 4'h3;
        drive(3'b000, '0, '0);
        #4;
        check("claim3b ready", 32'(claim_ready), 32'd1);
        expect_grant("claim3b", 3'b000);
        tick("claim3b");
        check("pending 0088", 32'(pending), 32'h0088);

        // Reset in the middle of a write drops it immediately.
        claim_valid = 1'b0;
        drive(3'b001, {4'h0, 4'h0, 4'hE}, {8'h00, 8'h00, 8'hEE});
        #4;
        expect_grant("wrE", 3'b001);
        tick("wrE");
        check("pre-reset pending", 32'(pending), 32'h0088);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset wen",     32'(reg_w_enable), 32'd0);
        check("async reset waddr",   32'(reg_w_addr),   32'd0);
        check("async reset pending", 32'(pending),      32'd0);
        check("async reset busy a",  32'(rd_a_busy),    32'd0);

        drive(3'b111, {4'h3, 4'h2, 4'h1}, {8'h33, 8'h22, 8'h11});
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #4;
        expect_grant("post reset 0", 3'b001);
        tick("post reset 0");
        #4;
        expect_grant("post reset 1", 3'b010);
        tick("post reset 1");

        drive(3'b000, '0, '0);
        #4;
        expect_grant("drain", 3'b000);
        tick("drain");
        check("queue empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
